// File: rtl/output_sram_arbiter_pkg.sv
// output_sram_arbiter_pkg: shared FSM type and
// default sizes for the output-SRAM write arbiter.
`ifndef OUTPUT_SRAM_ARBITER_DEFAULTS
`define OUTPUT_SRAM_ARBITER_DEFAULTS
`define NUM_BANKS 4
`define BEATS_PER_NODE 8
`endif

package output_sram_arbiter_pkg;

  localparam int MAX_NODE_ID = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_STREAM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/output_sram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// req/ptr in; one-hot gnt and its index idx out.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic found;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/output_sram_arbiter.sv
// output_sram_arbiter: round-robin owner of the output SRAM write port.
// Ports: bank_* request/beat inputs, req_grant, sram_* write, busy, proto_err.
module output_sram_arbiter
  import output_sram_arbiter_pkg::*;
#(
  parameter int NUM_BANKS      = `NUM_BANKS,
  parameter int DATA_W         = 16,
  parameter int NODE_W         = $clog2(MAX_NODE_ID),
  parameter int BEATS_PER_NODE = `BEATS_PER_NODE,
  parameter int ADDR_W         = NODE_W + $clog2(BEATS_PER_NODE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BANKS-1:0]        bank_req,
  output logic [NUM_BANKS-1:0]        req_grant,
  input  logic [NUM_BANKS-1:0]        bank_grant_valid,
  input  logic [NUM_BANKS-1:0]        bank_sos,
  input  logic [NUM_BANKS-1:0]        bank_eos,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_data,
  input  logic [NUM_BANKS*NODE_W-1:0] bank_node_id,
  output logic                        sram_wr_en,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  output logic                        busy,
  output logic                        proto_err
);

  localparam int IDX_W  = $clog2(NUM_BANKS);
  localparam int BEAT_W = $clog2(BEATS_PER_NODE);
  localparam int CNT_W  = BEAT_W + 1;

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]     owner, rr_ptr, ptr_nxt;
  logic [NODE_W-1:0]    node_id;
  logic [CNT_W-1:0]     beat_cnt;
  logic [NUM_BANKS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;

  logic              sel_valid, sel_sos, sel_eos;
  logic [DATA_W-1:0] sel_data;
  logic [NODE_W-1:0] sel_node;
  logic              wr_fire, err_set, latch_sos, cnt_full;
  logic [ADDR_W-1:0] wr_addr;

  rr_pick #(
    .N     (NUM_BANKS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (bank_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Only the owner's lanes are ever looked at.
  always_comb begin
    sel_valid = 1'b0;
    sel_sos   = 1'b0;
    sel_eos   = 1'b0;
    sel_data  = '0;
    sel_node  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (owner == IDX_W'(i)) begin
        sel_valid = bank_grant_valid[i];
        sel_sos   = bank_sos[i];
        sel_eos   = bank_eos[i];
        sel_data  = bank_data[i*DATA_W +: DATA_W];
        sel_node  = bank_node_id[i*NODE_W +: NODE_W];
      end
    end
  end

  assign cnt_full = (beat_cnt == CNT_W'(BEATS_PER_NODE));
  assign ptr_nxt  = (owner == IDX_W'(NUM_BANKS - 1)) ?
                    '0 : owner + IDX_W'(1);
  assign wr_addr  = latch_sos ?
                    {sel_node, {BEAT_W{1'b0}}} :
                    {node_id, beat_cnt[BEAT_W-1:0]};
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (|pick_gnt) state_nxt = ST_GRANT;
      ST_GRANT:
        state_nxt = (latch_sos && !sel_eos) ?
                    ST_STREAM : ST_IDLE;
      ST_STREAM:
        if (sel_valid && sel_eos) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // A repeated sos restarts addressing but is still written;
  // an overflow beat is dropped and the burst runs on to eos.
  always_comb begin
    req_grant = '0;
    wr_fire   = 1'b0;
    err_set   = 1'b0;
    latch_sos = 1'b0;
    unique case (1'b1)
      (state == ST_GRANT): begin
        req_grant = NUM_BANKS'(1) << owner;
        latch_sos = sel_valid & sel_sos;
        wr_fire   = sel_valid & sel_sos;
        err_set   = ~(sel_valid & sel_sos);
      end
      (state == ST_STREAM): begin
        if (sel_valid) begin
          if (sel_sos) begin
            latch_sos = 1'b1;
            wr_fire   = 1'b1;
            err_set   = 1'b1;
          end else if (cnt_full) begin
            err_set = 1'b1;
          end else begin
            wr_fire = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= '0;
      rr_ptr     <= '0;
      node_id    <= '0;
      beat_cnt   <= '0;
      proto_err  <= 1'b0;
      sram_wr_en <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      if (state == ST_IDLE && |pick_gnt) owner <= pick_idx;
      if (state == ST_GRANT) rr_ptr <= ptr_nxt;
      if (latch_sos) begin
        node_id  <= sel_node;
        beat_cnt <= CNT_W'(1);
      end else if (wr_fire) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (err_set) proto_err <= 1'b1;
      sram_wr_en <= wr_fire;
      if (wr_fire) begin
        sram_addr  <= wr_addr;
        sram_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_output_sram_arbiter.sv
// tb_output_sram_arbiter: directed checks of grant order,
// write sequencing, protocol errors and reset for the arbiter.
module tb_output_sram_arbiter;

  localparam int NB = 4;
  localparam int DW = 16;
  localparam int NW = 6;
  localparam int BPN = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] bank_req, req_grant;
  logic [NB-1:0] bank_grant_valid, bank_sos, bank_eos;
  logic [NB*DW-1:0] bank_data;
  logic [NB*NW-1:0] bank_node_id;
  logic          sram_wr_en, busy, proto_err;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  output_sram_arbiter #(
    .NUM_BANKS(NB), .DATA_W(DW), .NODE_W(NW),
    .BEATS_PER_NODE(BPN), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .bank_req(bank_req), .req_grant(req_grant),
    .bank_grant_valid(bank_grant_valid),
    .bank_sos(bank_sos), .bank_eos(bank_eos),
    .bank_data(bank_data), .bank_node_id(bank_node_id),
    .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .busy(busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bank_req = '0;
    bank_grant_valid = '0;
    bank_sos = '0;
    bank_eos = '0;
    bank_data = '0;
    bank_node_id = '0;
  endtask

  task automatic drive(input int b, input logic v, input logic s,
                       input logic e, input logic [DW-1:0] d,
                       input logic [NW-1:0] nid);
    bank_grant_valid[b] = v;
    bank_sos[b] = s;
    bank_eos[b] = e;
    bank_data[b*DW +: DW] = d;
    bank_node_id[b*NW +: NW] = nid;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({req_grant, sram_wr_en, sram_addr, sram_wdata, busy, proto_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got grant=%b wr=%b addr=%0d data=%h busy=%b err=%b want all 0",
               req_grant, sram_wr_en, sram_addr, sram_wdata, busy, proto_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    do_reset();
    bank_req = 4'b0100;
    tick();
    n_cmp++;
    if (req_grant !== 4'b0100 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: got grant=%b busy=%b want 0100/1", req_grant, busy);
    end
    bank_req = '0;
    for (int k = 0; k < 4; k++) begin
      d = {8'(2*k+1), 8'(2*k+2)};
      drive(2, 1'b1, k == 0, k == 3, d, 6'd7);
      tick();
      n_cmp++;
      if (req_grant !== 4'b0 || sram_wr_en !== 1'b1 ||
          sram_addr !== AW'(56 + k) || sram_wdata !== d) begin
        n_bad++;
        $display("FAIL single_write%0d: got g=%b wr=%b addr=%0d data=%h want 0/1/%0d/%h",
                 k, req_grant, sram_wr_en, sram_addr, sram_wdata, 56 + k, d);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy_fall: got %b want 0", busy);
    end
    clr();
    tick();
    n_cmp++;
    if (sram_wr_en !== 1'b0 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_tail: got wr=%b err=%b want 0/0", sram_wr_en, proto_err);
    end
  endtask

  task automatic test_round_robin();
    logic [NB-1:0] eg;
    int b;
    do_reset();
    bank_req = 4'hf;
    for (int i = 0; i < NB; i++)
      drive(i, 1'b1, 1'b1, 1'b1, DW'(16'h1000 + i), NW'(10 + i));
    for (int k = 1; k <= 9; k++) begin
      tick();
      eg = (k % 2 == 1) ? NB'(1 << (((k - 1) / 2) % 4)) : NB'(0);
      n_cmp++;
      if (req_grant !== eg) begin
        n_bad++;
        $display("FAIL rr_grant_c%0d: got %b want %b", k, req_grant, eg);
      end
      if (k % 2 == 0) begin
        b = ((k - 2) / 2) % 4;
        n_cmp++;
        if (sram_wr_en !== 1'b1 || sram_addr !== AW'((10 + b) * 8) ||
            sram_wdata !== DW'(16'h1000 + b)) begin
          n_bad++;
          $display("FAIL rr_write_c%0d: got wr=%b addr=%0d data=%h want 1/%0d/%h",
                   k, sram_wr_en, sram_addr, sram_wdata, (10 + b) * 8, 16'h1000 + b);
        end
      end
    end
    clr();
    tick();
    tick();
  endtask

  task automatic test_interleave();
    do_reset();
    bank_req = 4'b0010;
    tick();
    n_cmp++;
    if (req_grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL il_grant1: got %b want 0010", req_grant);
    end
    bank_req = 4'b1000;
    drive(1, 1'b1, 1'b1, 1'b0, 16'hA000, 6'd3);
    tick();
    n_cmp++;
    if (sram_wr_en !== 1'b1 || sram_addr !== 9'd24 || sram_wdata !== 16'hA000) begin
      n_bad++;
      $display("FAIL il_beat0: got wr=%b addr=%0d data=%h want 1/24/a000",
               sram_wr_en, sram_addr, sram_wdata);
    end
    drive(1, 1'b1, 1'b0, 1'b0, 16'hA001, 6'd3);
    tick();
    n_cmp++;
    if (sram_wr_en !== 1'b1 || sram_addr !== 9'd25 || sram_wdata !== 16'hA001) begin
      n_bad++;
      $display("FAIL il_beat1: got wr=%b addr=%0d data=%h want 1/25/a001",
               sram_wr_en, sram_addr, sram_wdata);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 6'd3);
    drive(3, 1'b1, 1'b1, 1'b1, 16'hBBBB, 6'd5);
    for (int g = 0; g < 2; g++) begin
      tick();
      n_cmp++;
      if (sram_wr_en !== 1'b0 || req_grant !== 4'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL il_gap%0d: got wr=%b grant=%b busy=%b want 0/0000/1",
                 g, sram_wr_en, req_grant, busy);
      end
    end
    drive(1, 1'b1, 1'b0, 1'b1, 16'hA002, 6'd3);
    tick();
    n_cmp++;
    if (sram_wr_en !== 1'b1 || sram_addr !== 9'd26 || sram_wdata !== 16'hA002 ||
        busy !== 1'b0 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL il_last: got wr=%b addr=%0d data=%h busy=%b err=%b want 1/26/a002/0/0",
               sram_wr_en, sram_addr, sram_wdata, busy, proto_err);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 6'd3);
    tick();
    n_cmp++;
    if (req_grant !== 4'b1000) begin
      n_bad++;
      $display("FAIL il_waiting_grant: got %b want 1000", req_grant);
    end
    bank_req = '0;
    tick();
    n_cmp++;
    if (sram_wr_en !== 1'b1 || sram_addr !== 9'd40 || sram_wdata !== 16'hBBBB) begin
      n_bad++;
      $display("FAIL il_bank3_write: got wr=%b addr=%0d data=%h want 1/40/bbbb",
               sram_wr_en, sram_addr, sram_wdata);
    end
    clr();
    tick();
  endtask

  task automatic test_no_sos();
    do_reset();
    bank_req = 4'b0001;
    tick();
    bank_req = '0;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h5555, 6'd1);
    tick();
    n_cmp++;
    if (proto_err !== 1'b1 || busy !== 1'b0 || sram_wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL nosos: got err=%b busy=%b wr=%b want 1/0/0",
               proto_err, busy, sram_wr_en);
    end
    clr();
    tick();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL nosos_sticky: got %b want 1", proto_err);
    end
  endtask

  task automatic test_overflow();
    int nwr;
    nwr = 0;
    do_reset();
    bank_req = 4'b0100;
    tick();
    bank_req = '0;
    for (int k = 0; k <= 8; k++) begin
      drive(2, 1'b1, k == 0, k == 8, DW'(16'h2000 + k), 6'd1);
      tick();
      if (sram_wr_en === 1'b1) nwr++;
      if (k < 8) begin
        n_cmp++;
        if (sram_wr_en !== 1'b1 || sram_addr !== AW'(8 + k) ||
            sram_wdata !== DW'(16'h2000 + k) || proto_err !== 1'b0) begin
          n_bad++;
          $display("FAIL ovf_beat%0d: got wr=%b addr=%0d data=%h err=%b want 1/%0d/%h/0",
                   k, sram_wr_en, sram_addr, sram_wdata, proto_err, 8 + k, 16'h2000 + k);
        end
      end
    end
    n_cmp++;
    if (sram_wr_en !== 1'b0 || proto_err !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_ninth: got wr=%b err=%b busy=%b want 0/1/0",
               sram_wr_en, proto_err, busy);
    end
    n_cmp++;
    if (nwr !== 8) begin
      n_bad++;
      $display("FAIL ovf_count: got %0d writes want 8", nwr);
    end
    clr();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bank_req = 4'b0001;
    tick();
    bank_req = '0;
    drive(0, 1'b1, 1'b1, 1'b0, 16'h3000, 6'd2);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 16'h3001, 6'd2);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 16'h3002, 6'd2);
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({req_grant, sram_wr_en, sram_addr, sram_wdata, busy, proto_err} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got grant=%b wr=%b addr=%0d data=%h busy=%b err=%b want all 0",
               req_grant, sram_wr_en, sram_addr, sram_wdata, busy, proto_err);
    end
    reset = 1'b0;
    clr();
    bank_req = 4'b0011;
    tick();
    n_cmp++;
    if (req_grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL midrst_ptr: got %b want 0001", req_grant);
    end
    bank_req = '0;
    drive(0, 1'b1, 1'b1, 1'b1, 16'h3333, 6'd2);
    tick();
    n_cmp++;
    if (sram_wr_en !== 1'b1 || sram_addr !== 9'd16 || sram_wdata !== 16'h3333) begin
      n_bad++;
      $display("FAIL midrst_next: got wr=%b addr=%0d data=%h want 1/16/3333",
               sram_wr_en, sram_addr, sram_wdata);
    end
    clr();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clr();
    test_reset();
    test_single();
    test_round_robin();
    test_interleave();
    test_no_sos();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/output_sram_arbiter.md
# output_sram_arbiter

Round-robin arbiter and write sequencer that shares the single output-buffer SRAM write port among `NUM_BANKS` vertex accumulation banks. It samples each bank's output request and issues a one-cycle grant to exactly one bank. It then owns the port for that bank's burst, from the `sos` beat to the `eos` beat. Each accepted beat becomes a registered SRAM write at an address derived from the bank's node id and the beat index.

## Interface
- `NUM_BANKS`, 4: number of requesting vertex banks.
- `DATA_W`, 16: beat width (`FV_bandwidth`, two 8-bit FVs per beat).
- `NODE_W`, `$clog2(Max_Node_id)`: node id width.
- `BEATS_PER_NODE`, 8: maximum beats per node (`MAX_FV_num/2`); power of two.
- `ADDR_W`, `NODE_W+$clog2(BEATS_PER_NODE)`: SRAM address width (derived).
- Clock and reset: `clk`; `reset` is synchronous and active-high.
- `bank_req`  in  `NUM_BANKS`  per-bank request, level, held until granted.
- `req_grant`  out  `NUM_BANKS`  one-hot grant pulse, one cycle.
- `bank_grant_valid`  in  `NUM_BANKS`  per-bank beat-valid.
- `bank_sos`, `bank_eos`  in  `NUM_BANKS` each  per-bank start/end-of-stream flags.
- `bank_data`  in  `NUM_BANKS*DATA_W`  flattened beat data; bank i is at `[i*DATA_W +: DATA_W]`.
- `bank_node_id`  in  `NUM_BANKS*NODE_W`  flattened node id per bank.
- `sram_wr_en`  out  1  SRAM write strobe.
- `sram_addr`  out  `ADDR_W`  SRAM write address.
- `sram_wdata`  out  `DATA_W`  SRAM write data.
- `busy`  out  1  high whenever state is not IDLE.
- `proto_err`  out  1  sticky protocol-error flag, cleared only by reset.

## Operation
- States:
  - IDLE: ownership free.
  - GRANT: `req_grant` is driven this cycle.
  - STREAM: owner bank is mid-burst.
- IDLE → GRANT: any `bank_req` bit is set. Winner is the first requester at or after `rr_ptr`, searching upward with wrap. The winner index is registered as `owner`.
- GRANT: `req_grant[owner]=1`. The owner must present its first beat in this same cycle (`grant_valid=1`, `sos=1`).
  - First beat with `eos=1`: single-beat burst; go to IDLE.
  - First beat with `eos=0`: go to STREAM.
  - No valid `sos` beat: set `proto_err`, no write, go to IDLE.
- STREAM: each cycle with `bank_grant_valid[owner]=1` is a beat. The beat with `eos=1` returns to IDLE. Cycles without valid insert no write and keep STREAM.
- Inputs from non-owner banks are ignored in GRANT and STREAM, including their `grant_valid`, `sos` and `eos`.
- `rr_ptr` is set to `owner+1` (mod `NUM_BANKS`) at the GRANT cycle. Reset value is 0.
- Addressing:
  - `node_id` is latched from the owner on the `sos` beat.
  - `beat_cnt` resets to 0 on `sos` and increments per beat.
  - `sram_addr = {node_id, beat_cnt}`.
- A beat with `beat_cnt == BEATS_PER_NODE` sets `proto_err` and is not written. The burst continues until `eos`.
- `sos` seen in STREAM sets `proto_err`. That beat is written, and `beat_cnt` restarts at 0.
- Reset mid-burst: all state clears, no write is issued the cycle after reset, and the owner's burst is abandoned.

## Timing
- Reset values: `req_grant=0`, `sram_wr_en=0`, `sram_addr=0`, `sram_wdata=0`, `busy=0`, `proto_err=0`, state IDLE, `rr_ptr=0`.
- Request to grant: `bank_req` seen in IDLE at cycle N gives `req_grant` at N+1, registered, pulse exactly one cycle.
- Beat to write: a beat accepted at cycle M gives `sram_wr_en`, `sram_addr` and `sram_wdata` at M+1 (one-stage register).
- Turnaround: `eos` beat at cycle M puts the block in IDLE at M+1. The next grant can come at M+2. Back-to-back bursts have a minimum 1 idle cycle.
- Grants are never issued while busy. Requests that arrive during a burst wait.

## Structure
- The shared package (with `Vertex2Accu_Bank`, `Bank_Req2Req_Output_SRAM`) holds:
  - state typedef `arb_state_t`;
  - `NUM_BANKS` and `BEATS_PER_NODE` defaults as `define`s.
- One sub-module, `rr_pick`: combinational round-robin priority picker. Inputs are `req` and `ptr`; outputs are one-hot `gnt` and index `idx`.

## Test plan
- Single bank: bank 2 requests at cycle 5 → `req_grant=4'b0100` at cycle 6 only. Bank 2 sends 4 beats, node id 7, data 0x0102 to 0x0708. Writes occur at cycles 7–10 to addresses 56–59 with that data; `busy` falls at cycle 10.
- Round-robin: all 4 banks request continuously with 1-beat bursts → grant order 0,1,2,3,0, with grants 2 cycles apart.
- Interleaving: owner bank 1 drops `grant_valid` for 2 cycles mid-burst, while bank 3 asserts `grant_valid`, `sos` and `eos` → no writes in the gap, no writes from bank 3, burst completes correctly.
- Errors:
  - Owner sends no valid `sos` beat in the grant cycle → `proto_err=1`, IDLE next cycle, no write.
  - 9-beat burst → 8 writes, `proto_err=1`.
- Reset during STREAM after 2 beats → all outputs 0 the next cycle, `rr_ptr=0`, next request granted normally.
